// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/done handshake.
// Optional range check (saturate to all-9s and raise ovf) under macro BIN2BCD_RANGE_CHK_EN.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One double-dabble iteration: add-3 correction on every digit, then shift left by one.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[BIN_W+4*i +: 4] >= 4'd5) begin
        t[BIN_W+4*i +: 4] = t[BIN_W+4*i +: 4] + 4'd3;
      end
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

`ifdef BIN2BCD_RANGE_CHK_EN
  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

  localparam logic [31:0] BCD_MAX = pow10(DIGITS) - 32'd1;

  logic range_err_q, range_err_d;
  logic ovf_q, ovf_d;
`endif

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SR_W-1:0]   step_s;

  assign step_s = dd_step(sr_q);

  // Next-state and next-output logic; outputs are computed here and registered below.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef BIN2BCD_RANGE_CHK_EN
    range_err_d = range_err_q;
    ovf_d       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = {{BCD_W{1'b0}}, bin_in};
          cnt_d   = CNT_W'(BIN_W);
          busy_d  = 1'b1;
          state_d = S_CONV;
`ifdef BIN2BCD_RANGE_CHK_EN
          range_err_d = (32'(bin_in) > BCD_MAX);
`endif
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        sr_d   = step_s;
        cnt_d  = cnt_q - CNT_W'(1);
        busy_d = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          // Bits shifted out above the top digit are dropped: result wraps modulo 10^DIGITS.
          bcd_d   = step_s[SR_W-1 -: BCD_W];
          done_d  = 1'b1;
          state_d = S_DONE;
`ifdef BIN2BCD_RANGE_CHK_EN
          if (range_err_q) begin
            bcd_d = {DIGITS{4'h9}};
          end else begin
            bcd_d = step_s[SR_W-1 -: BCD_W];
          end
          ovf_d = range_err_q;
`endif
        end else begin
          state_d = S_CONV;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= {SR_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      bcd_q   <= {BCD_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef BIN2BCD_RANGE_CHK_EN
  // Range-check flag captured at start and the registered ovf output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      range_err_q <= range_err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: a 3-digit instance and a 2-digit overflow instance.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start, start2;
  logic [7:0]  bin_in, bin_in2;
  logic        busy, busy2;
  logic        done, done2;
  logic [11:0] bcd_out;
  logic [7:0]  bcd_out2;
  logic        ovf, ovf2;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin_in(bin_in2),
    .busy(busy2), .done(done2), .bcd_out(bcd_out2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Runs one conversion on the 3-digit DUT; returns at a negedge with the DUT back in IDLE.
  task automatic conv1(input logic [7:0] v, output int lat, output int busy_cnt,
                       output logic [11:0] res, output bit early_chg);
    logic [11:0] prev;
    prev = bcd_out;
    early_chg = 1'b0;
    start = 1'b1;
    bin_in = v;
    @(negedge clk);
    start = 1'b0;
    bin_in = ~v;
    lat = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (bcd_out !== prev) early_chg = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (busy === 1'b1) busy_cnt++;
    res = bcd_out;
    @(negedge clk);
  endtask

  task automatic conv2(input logic [7:0] v, output int lat, output logic [7:0] res,
                       output logic ovf_at_done);
    start2 = 1'b1;
    bin_in2 = v;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (done2 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = bcd_out2;
    ovf_at_done = ovf2;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; bin_in = 8'd0;
    start2 = 1'b0; bin_in2 = 8'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, ovf, bcd_out} !== 15'd0) begin
      errors++; $display("FAIL reset_outputs: got %b/%b/%b/%h want 0/0/0/000", busy, done, ovf, bcd_out);
    end
    checks++;
    if ({busy2, done2, ovf2, bcd_out2} !== 11'd0) begin
      errors++; $display("FAIL reset_outputs2: got %b/%b/%b/%h want 0/0/0/00", busy2, done2, ovf2, bcd_out2);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int lat, bc; logic [11:0] res; bit chg;
    conv1(8'd0, lat, bc, res, chg);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL zero_latency: got %0d edges want 8", lat); end
    checks++;
    if (bc !== 9) begin errors++; $display("FAIL zero_busy_cycles: got %0d want 9", bc); end
    checks++;
    if (res !== 12'h000) begin errors++; $display("FAIL zero_result: got %h want 000", res); end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_one_cycle: done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_vectors();
    logic [7:0]  vin [5]  = '{8'd255, 8'd99, 8'd100, 8'd173, 8'd9};
    logic [11:0] vexp [5] = '{12'h255, 12'h099, 12'h100, 12'h173, 12'h009};
    int lat, bc; logic [11:0] res; bit chg;
    for (int i = 0; i < 5; i++) begin
      conv1(vin[i], lat, bc, res, chg);
      checks++;
      if (res !== vexp[i]) begin errors++; $display("FAIL vector_%0d: got %h want %h", vin[i], res, vexp[i]); end
      checks++;
      if (chg) begin errors++; $display("FAIL bcd_stable_%0d: changed=1 want 0 before done", vin[i]); end
    end
  endtask

  task automatic test_exhaustive();
    int lat, bc; logic [11:0] res; bit chg;
    for (int v = 0; v < 256; v++) begin
      conv1(8'(v), lat, bc, res, chg);
      checks++;
      if (res !== ref_bcd(v) || lat !== 8) begin
        errors++; $display("FAIL exhaustive_%0d: got %h lat %0d want %h lat 8", v, res, lat, ref_bcd(v));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [21];
    int ndone;
    int dn_at [3];
    logic [11:0] dn_val [3];
    for (int i = 0; i < 21; i++) vals[i] = 8'((i * 37 + 11) % 256);
    ndone = 0;
    for (int n = 0; n < 35; n++) begin
      if (n < 21) begin start = 1'b1; bin_in = vals[n]; end
      else begin start = 1'b0; bin_in = 8'd0; end
      @(negedge clk);
      if (n == 9 || n == 19) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap_%0d: busy=%b want 0", n, busy); end
      end
      if (done === 1'b1) begin
        if (ndone < 3) begin dn_at[ndone] = n; dn_val[ndone] = bcd_out; end
        ndone++;
      end
    end
    checks++;
    if (ndone !== 3) begin errors++; $display("FAIL b2b_count: got %0d dones want 3", ndone); end
    for (int j = 0; j < 3 && j < ndone; j++) begin
      checks++;
      if (dn_at[j] !== 8 + 10 * j || dn_val[j] !== ref_bcd(int'(vals[10 * j]))) begin
        errors++;
        $display("FAIL b2b_result_%0d: got %h at %0d want %h at %0d", j, dn_val[j], dn_at[j],
                 ref_bcd(int'(vals[10 * j])), 8 + 10 * j);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, ndone; logic [11:0] res; bit chg;
    start = 1'b1; bin_in = 8'd173;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, ovf, bcd_out} !== 15'd0) begin
      errors++; $display("FAIL reset_mid_outputs: got %b/%b/%b/%h want 0/0/0/000", busy, done, ovf, bcd_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0 || bcd_out !== 12'h000) begin
      errors++; $display("FAIL reset_mid_no_done: got %0d dones bcd %h want 0 dones bcd 000", ndone, bcd_out);
    end
    conv1(8'd42, lat, bc, res, chg);
    checks++;
    if (res !== 12'h042) begin errors++; $display("FAIL reset_mid_recover: got %h want 042", res); end
  endtask

  task automatic test_overflow();
    int lat; logic [7:0] res; logic ov;
    logic [7:0] exp150;
    logic       expov;
`ifdef BIN2BCD_RANGE_CHK_EN
    exp150 = 8'h99; expov = 1'b1;
`else
    exp150 = 8'h50; expov = 1'b0;
`endif
    conv2(8'd150, lat, res, ov);
    checks++;
    if (res !== exp150 || ov !== expov || lat !== 8) begin
      errors++; $display("FAIL ovf_150: got %h ovf %b lat %0d want %h ovf %b lat 8", res, ov, lat, exp150, expov);
    end
    checks++;
    if (ovf2 !== 1'b0) begin errors++; $display("FAIL ovf_clears: got %b want 0", ovf2); end
    conv2(8'd99, lat, res, ov);
    checks++;
    if (res !== 8'h99 || ov !== 1'b0) begin
      errors++; $display("FAIL ovf_99: got %h ovf %b want 99 ovf 0", res, ov);
    end
    conv2(8'd42, lat, res, ov);
    checks++;
    if (res !== 8'h42 || ov !== 1'b0) begin
      errors++; $display("FAIL ovf_42: got %h ovf %b want 42 ovf 0", res, ov);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_vectors();
    test_exhaustive();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
